// File: rtl/imm_gen_pkg.sv
// Shared opcodes and immediate-format encoding for the decode-stage immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_FENCE    = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_gen_core.sv
// Combinational instruction-format classifier and immediate extractor.
module imm_gen_core
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [20:0] j_raw;
  logic [12:0] b_raw;
  logic [11:0] s_raw;
  logic [11:0] i_raw;
  logic [31:0] u_raw;
  logic        is_rv64;

  assign opcode  = instr_i[6:0];
  assign is_rv64 = (XLEN == 64);
  assign j_raw   = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign b_raw   = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign s_raw   = {instr_i[31:25], instr_i[11:7]};
  assign i_raw   = instr_i[31:20];
  assign u_raw   = {instr_i[31:12], 12'b0};

  // Decode opcode into format, sign/zero-extended immediate and illegal flag
  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      unique case (opcode)
        OP_JAL: begin
          fmt_o = FMT_J;
          imm_o = XLEN'($signed(j_raw));
        end
        OP_BRANCH: begin
          fmt_o = FMT_B;
          imm_o = XLEN'($signed(b_raw));
        end
        OP_STORE: begin
          fmt_o = FMT_S;
          imm_o = XLEN'($signed(s_raw));
        end
        OP_LUI, OP_AUIPC: begin
          fmt_o = FMT_U;
          imm_o = XLEN'($signed(u_raw));
        end
        OP_JALR, OP_LOAD, OP_OP_IMM: begin
          fmt_o = FMT_I;
          imm_o = XLEN'($signed(i_raw));
        end
        OP_OP_IMM32: begin
          if (is_rv64) begin
            fmt_o = FMT_I;
            imm_o = XLEN'($signed(i_raw));
          end else begin
            illegal_o = 1'b1;
          end
        end
        OP_SYSTEM: begin
          // CSR-immediate forms carry a 5-bit unsigned zimm in the rs1 field
          if (ENABLE_ZIMM && instr_i[14]) begin
            fmt_o = FMT_Z;
            imm_o = XLEN'(instr_i[19:15]);
          end
        end
        OP_OP, OP_FENCE: ;
        OP_OP32: illegal_o = !is_rv64;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator stage with a 2-entry skid buffer and flush.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_imm_o,
  output imm_fmt_e        out_fmt_o,
  output logic            out_illegal_o,
  output logic [31:0]     out_instr_o,
  output logic [XLEN-1:0] out_pc_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } beat_t;

  beat_t main_q, main_d, skid_q, skid_d, new_beat;
  logic  main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic  in_xfer, out_xfer;

  imm_gen_core #(
    .XLEN        (XLEN),
    .ENABLE_ZIMM (ENABLE_ZIMM)
  ) u_core (
    .instr_i   (in_instr_i),
    .imm_o     (new_beat.imm),
    .fmt_o     (new_beat.fmt),
    .illegal_o (new_beat.illegal)
  );

  assign new_beat.instr = in_instr_i;
  assign new_beat.pc    = in_pc_i;

  // Ready depends only on registered skid occupancy, never on out_ready_i
  assign in_ready_o = !skid_vld_q;
  assign in_xfer    = in_valid_i && in_ready_o;
  assign out_xfer   = main_vld_q && out_ready_i;

  // Skid-buffer next state: refill main from skid first, else from input; flush wins
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_xfer) begin
      // skid can only be occupied while main is, and then in_ready is low
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        main_d     = new_beat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d     = new_beat;
      skid_vld_d = 1'b1;
    end
  end

  // State registers; async reset clears valids and payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid_o   = main_vld_q;
  assign out_imm_o     = main_q.imm;
  assign out_fmt_o     = main_q.fmt;
  assign out_illegal_o = main_q.illegal;
  assign out_instr_o   = main_q.instr;
  assign out_pc_o      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: RV32 and RV64 instances driven from shared stimulus.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, ins32, pc32;
  logic [2:0]  fmt32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, pc64;
  logic [31:0] ins64;
  logic [2:0]  fmt64;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .ENABLE_ZIMM(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .in_instr_i(instr), .in_pc_i(pc[31:0]), .out_valid_o(vld32), .out_ready_i(out_ready),
    .out_imm_o(imm32), .out_fmt_o(fmt32), .out_illegal_o(ill32), .out_instr_o(ins32),
    .out_pc_o(pc32)
  );

  imm_gen_pipe #(.XLEN(64), .ENABLE_ZIMM(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .in_instr_i(instr), .in_pc_i(pc), .out_valid_o(vld64), .out_ready_i(out_ready),
    .out_imm_o(imm64), .out_fmt_o(fmt64), .out_illegal_o(ill64), .out_instr_o(ins64),
    .out_pc_o(pc64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a beat at the falling edge, sample #1 after the next rising edge
  task automatic send(input logic [31:0] ins, input logic [63:0] p);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = ins;
    pc       = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0;
    #12;
    chk("rst_vld", 64'(vld32), 64'd0);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_ins", 64'(ins32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", 64'(rdy32), 64'd1);

    // 1: addi -1
    send(32'hFFF00093, 64'h1000);
    chk("addi_vld", 64'(vld32), 64'd1);
    chk("addi_imm32", 64'(imm32), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(fmt32), 64'(FMT_I));
    chk("addi_ill", 64'(ill32), 64'd0);
    chk("addi_pc", 64'(pc32), 64'h1000);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);

    // 2: jal / beq / sw
    send(32'hFFDFF06F, 64'h1004);
    chk("jal_imm", 64'(imm32), 64'hFFFFFFFC);
    chk("jal_fmt", 64'(fmt32), 64'(FMT_J));
    send(32'hFE000EE3, 64'h1008);
    chk("beq_imm", 64'(imm32), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(fmt32), 64'(FMT_B));
    send(32'hFE112E23, 64'h100C);
    chk("sw_imm", 64'(imm32), 64'hFFFFFFFC);
    chk("sw_fmt", 64'(fmt32), 64'(FMT_S));

    // 3: lui, csrrwi, addiw, add, compressed-looking
    send(32'h800000B7, 64'h1010);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt64", 64'(fmt64), 64'(FMT_U));
    chk("lui_imm32", 64'(imm32), 64'h80000000);
    send(32'h3002D073, 64'h1014);
    chk("csr_imm", imm64, 64'd5);
    chk("csr_fmt", 64'(fmt64), 64'(FMT_Z));
    send(32'h0000001B, 64'h1018);
    chk("w32_ill", 64'(ill32), 64'd1);
    chk("w32_imm", 64'(imm32), 64'd0);
    chk("w32_fmt", 64'(fmt32), 64'(FMT_NONE));
    chk("w64_ill", 64'(ill64), 64'd0);
    chk("w64_fmt", 64'(fmt64), 64'(FMT_I));
    send(32'h00000033, 64'h101C);
    chk("add_ill", 64'(ill32), 64'd0);
    chk("add_fmt", 64'(fmt32), 64'(FMT_NONE));
    send(32'h00100010, 64'h1020);
    chk("c16_ill", 64'(ill32), 64'd1);
    chk("c16_imm", 64'(imm32), 64'd0);
    tick();
    chk("idle_vld", 64'(vld32), 64'd0);

    // 4: back-pressure with beats A,B,C
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h00100093, 64'h2000);
    send(32'h00200093, 64'h2004);
    chk("bp_rdy_lo", 64'(rdy32), 64'd0);
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h00300093; pc = 64'h2008;
    tick();
    tick();
    chk("bp_hold_vld", 64'(vld32), 64'd1);
    chk("bp_hold_ins", 64'(ins32), 64'h00100093);
    chk("bp_hold_imm", 64'(imm32), 64'd1);
    chk("bp_hold_rdy", 64'(rdy32), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp_B", 64'(imm32), 64'd2);
    chk("bp_rdy_hi", 64'(rdy32), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_C", 64'(imm32), 64'd3);
    chk("bp_C_pc", 64'(pc32), 64'h2008);
    tick();
    chk("bp_empty", 64'(vld32), 64'd0);

    // 5: flush with both entries full and beat D presented
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h00100093, 64'h3000);
    send(32'h00200093, 64'h3004);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00400093; pc = 64'h3008;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld", 64'(vld32), 64'd0);
    chk("fl_rdy", 64'(rdy32), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    tick();
    chk("fl_noD", 64'(vld32), 64'd0);

    // 6: async reset mid-stream
    send(32'h00700093, 64'h4000);
    chk("ar_pre", 64'(vld32), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 64'(vld32), 64'd0);
    chk("ar_imm", 64'(imm32), 64'd0);
    chk("ar_vld64", 64'(vld64), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h00800093, 64'h4004);
    chk("ar_lat_vld", 64'(vld32), 64'd1);
    chk("ar_lat_imm", 64'(imm32), 64'd8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
